// File: rtl/modulo_escalonador_reabastecimento_rolhas_if.sv
// Cork buffer scheduler bus: request inputs, buffer levels and issue outputs.
interface modulo_escalonador_reabastecimento_rolhas_if #(
    parameter int unsigned W = 7
);
    logic         enable;
    logic         ve_pulse;
    logic         op_req;
    logic [W-1:0] nivel_princ;
    logic [W-1:0] nivel_sec;
    logic [1:0]   perm;
    logic         load_princ;
    logic         load_sec;
    logic         busy;
    logic         ro;
    logic         falha_sec;
    logic         descarte;

    // Environment side: raises requests, owns the level registers.
    modport master (
        output enable, ve_pulse, op_req, nivel_princ, nivel_sec,
        input  perm, load_princ, load_sec, busy, ro, falha_sec, descarte
    );

    // Scheduler side.
    modport slave (
        input  enable, ve_pulse, op_req, nivel_princ, nivel_sec,
        output perm, load_princ, load_sec, busy, ro, falha_sec, descarte
    );
endinterface

// File: rtl/modulo_escalonador_reabastecimento_rolhas.sv
// Cork buffer sequencer: one issue slot per cycle shared by sealing
// consumption, automatic batch refill and operator manual add.
module modulo_escalonador_reabastecimento_rolhas #(
    parameter int unsigned W         = 7,
    parameter int unsigned CAP_MAX   = 99,
    parameter int unsigned MIN_NIVEL = 5,
    parameter int unsigned LOTE      = 20
) (
    input  logic clk,
    input  logic clr,
    modulo_escalonador_reabastecimento_rolhas_if.slave bus
);

    localparam int unsigned WE = W + 1;

    localparam logic [1:0] PERM_NONE = 2'b00;
    localparam logic [1:0] PERM_LOTE = 2'b01;
    localparam logic [1:0] PERM_ADD1 = 2'b10;
    localparam logic [1:0] PERM_SUB1 = 2'b11;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CONSOME   = 3'd1,
        TRANSFERE = 3'd2,
        MANUAL    = 3'd3,
        ESPERA    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       pend_ve_q, pend_ve_d;
    logic       pend_op_q, pend_op_d;
    logic [1:0] perm_q, perm_d;
    logic       load_princ_q, load_princ_d;
    logic       load_sec_q, load_sec_d;
    logic       busy_q, busy_d;
    logic       falha_q, falha_d;
    logic       descarte_q, descarte_d;

    logic princ_zero;
    logic princ_cheio;
    logic sec_ok;
    logic refill_need;

    // Level comparisons; the batch fit check is one bit wider so it cannot wrap.
    assign princ_zero  = (bus.nivel_princ == '0);
    assign princ_cheio = (bus.nivel_princ >= W'(CAP_MAX));
    assign sec_ok      = (bus.nivel_sec >= W'(LOTE));
    assign refill_need = (bus.nivel_princ < W'(MIN_NIVEL)) &&
                         ((WE'(bus.nivel_princ) + WE'(LOTE)) <= WE'(CAP_MAX));

    // Next-state, pending flags and issue decision.
    always_comb begin
        state_d      = state_q;
        pend_ve_d    = pend_ve_q | bus.ve_pulse;
        pend_op_d    = pend_op_q | bus.op_req;
        perm_d       = PERM_NONE;
        load_princ_d = 1'b0;
        load_sec_d   = 1'b0;
        falha_d      = falha_q;
        descarte_d   = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (sec_ok) begin
                    falha_d = 1'b0;
                end
                if (bus.enable) begin
                    if (pend_ve_q) begin
                        pend_ve_d = 1'b0;
                        if (princ_zero) begin
                            descarte_d = 1'b1;
                        end else begin
                            state_d      = CONSOME;
                            perm_d       = PERM_SUB1;
                            load_princ_d = 1'b1;
                        end
                    end else if (refill_need && sec_ok) begin
                        state_d      = TRANSFERE;
                        perm_d       = PERM_LOTE;
                        load_princ_d = 1'b1;
                        load_sec_d   = 1'b1;
                    end else begin
                        // A failed refill never holds back operator service.
                        if (refill_need) begin
                            falha_d = 1'b1;
                        end
                        if (pend_op_q) begin
                            pend_op_d = 1'b0;
                            if (princ_cheio) begin
                                descarte_d = 1'b1;
                            end else begin
                                state_d      = MANUAL;
                                perm_d       = PERM_ADD1;
                                load_princ_d = 1'b1;
                            end
                        end
                    end
                end
            end
            CONSOME, TRANSFERE, MANUAL: state_d = ESPERA;
            ESPERA:                     state_d = OCIOSO;
            default:                    state_d = OCIOSO;
        endcase

        busy_d = (state_d != OCIOSO);
    end

    // State, pending flags and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= OCIOSO;
            pend_ve_q    <= 1'b0;
            pend_op_q    <= 1'b0;
            perm_q       <= PERM_NONE;
            load_princ_q <= 1'b0;
            load_sec_q   <= 1'b0;
            busy_q       <= 1'b0;
            falha_q      <= 1'b0;
            descarte_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_ve_q    <= pend_ve_d;
            pend_op_q    <= pend_op_d;
            perm_q       <= perm_d;
            load_princ_q <= load_princ_d;
            load_sec_q   <= load_sec_d;
            busy_q       <= busy_d;
            falha_q      <= falha_d;
            descarte_q   <= descarte_d;
        end
    end

    assign bus.perm       = perm_q;
    assign bus.load_princ = load_princ_q;
    assign bus.load_sec   = load_sec_q;
    assign bus.busy       = busy_q;
    assign bus.falha_sec  = falha_q;
    assign bus.descarte   = descarte_q;
    assign bus.ro         = princ_zero;

endmodule

// File: tb/tb_modulo_escalonador_reabastecimento_rolhas.sv
// Bench for the cork buffer scheduler: cycle model plus directed scenarios.
module tb_modulo_escalonador_reabastecimento_rolhas;

    localparam int unsigned W    = 7;
    localparam int          CAP  = 99;
    localparam int          MINN = 5;
    localparam int          LOTE = 20;

    // Model state: pending requests, slot lockout countdown and expected outputs.
    typedef struct packed {
        logic       pve;
        logic       pop;
        logic [1:0] hold;
        logic [1:0] perm;
        logic       lp;
        logic       ls;
        logic       busy;
        logic       falha;
        logic       desc;
    } model_t;

    logic       clk = 1'b0;
    logic       clr;
    int         checks = 0;
    int         errors = 0;
    int         cyc_n  = 0;
    int         n_lp   = 0;
    int         n_ls   = 0;
    int         n_desc = 0;
    bit         chk_en = 1'b0;
    logic [1:0] log_perm[$];
    int         log_cyc[$];
    model_t     m;
    logic       prev_lp;
    logic       prev_ls;
    logic [1:0] prev_perm;

    modulo_escalonador_reabastecimento_rolhas_if #(.W(W)) bus ();

    modulo_escalonador_reabastecimento_rolhas #(
        .W(W), .CAP_MAX(99), .MIN_NIVEL(5), .LOTE(20)
    ) u_dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // One slot: a served request strobes next cycle, then the slot rests one cycle.
    function automatic model_t model_step(input model_t s, input logic en, input logic vp,
                                          input logic op, input int p, input int sc);
        model_t n;
        bit     done;
        n      = s;
        done   = 1'b0;
        n.perm = 2'b00;
        n.lp   = 1'b0;
        n.ls   = 1'b0;
        n.desc = 1'b0;
        n.pve  = s.pve | vp;
        n.pop  = s.pop | op;
        if (s.hold != 2'd0) begin
            n.hold = s.hold - 2'd1;
            n.busy = (n.hold != 2'd0);
        end else begin
            n.busy = 1'b0;
            if (sc >= LOTE) n.falha = 1'b0;
            if (en) begin
                if (s.pve) begin
                    n.pve = 1'b0;
                    done  = 1'b1;
                    if (p == 0) n.desc = 1'b1;
                    else begin n.perm = 2'b11; n.lp = 1'b1; end
                end else if (p < MINN && p + LOTE <= CAP) begin
                    if (sc >= LOTE) begin
                        n.perm = 2'b01; n.lp = 1'b1; n.ls = 1'b1; done = 1'b1;
                    end else begin
                        n.falha = 1'b1;
                    end
                end
                if (!done && s.pop) begin
                    n.pop = 1'b0;
                    if (p < CAP) begin n.perm = 2'b10; n.lp = 1'b1; end
                    else n.desc = 1'b1;
                end
                if (n.lp) begin
                    n.hold = 2'd2;
                    n.busy = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) m <= '0;
        else     m <= model_step(m, bus.enable, bus.ve_pulse, bus.op_req,
                                 int'(bus.nivel_princ), int'(bus.nivel_sec));
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc_n, act, req);
        end
    endtask

    // Per-cycle comparison against the model, plus strobe bookkeeping.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("perm",       8'(bus.perm),       8'(m.perm));
            chk("load_princ", 8'(bus.load_princ), 8'(m.lp));
            chk("load_sec",   8'(bus.load_sec),   8'(m.ls));
            chk("busy",       8'(bus.busy),       8'(m.busy));
            chk("falha_sec",  8'(bus.falha_sec),  8'(m.falha));
            chk("descarte",   8'(bus.descarte),   8'(m.desc));
            chk("ro",         8'(bus.ro),         8'(bus.nivel_princ == '0));
            if (bus.load_princ) begin
                n_lp <= n_lp + 1;
                log_perm.push_back(bus.perm);
                log_cyc.push_back(cyc_n);
            end
            if (bus.load_sec) n_ls   <= n_ls + 1;
            if (bus.descarte) n_desc <= n_desc + 1;
        end
    end

    // Advance one cycle; the level registers take the strobe of the cycle just ended.
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.ve_pulse = 1'b0;
        bus.op_req   = 1'b0;
        if (prev_lp) begin
            case (prev_perm)
                2'b01:   bus.nivel_princ = bus.nivel_princ + W'(LOTE);
                2'b10:   bus.nivel_princ = bus.nivel_princ + 7'd1;
                2'b11:   bus.nivel_princ = bus.nivel_princ - 7'd1;
                default: ;
            endcase
        end
        if (prev_ls) bus.nivel_sec = bus.nivel_sec - W'(LOTE);
        prev_lp   = bus.load_princ;
        prev_ls   = bus.load_sec;
        prev_perm = bus.perm;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_lvl(input int p, input int s);
        bus.nivel_princ = W'(p);
        bus.nivel_sec   = W'(s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  b_lp, b_ls, b_desc;
        bit  found;
        clr          = 1'b1;
        bus.enable   = 1'b1;
        bus.ve_pulse = 1'b0;
        bus.op_req   = 1'b0;
        prev_lp      = 1'b0;
        prev_ls      = 1'b0;
        prev_perm    = 2'b00;
        set_lvl(50, 40);
        run(3);
        chk("rst_perm",  8'(bus.perm),       8'd0);
        chk("rst_lp",    8'(bus.load_princ), 8'd0);
        chk("rst_ls",    8'(bus.load_sec),   8'd0);
        chk("rst_busy",  8'(bus.busy),       8'd0);
        chk("rst_falha", 8'(bus.falha_sec),  8'd0);
        chk("rst_desc",  8'(bus.descarte),   8'd0);
        chk_en = 1'b1;
        clr    = 1'b0;

        // Idle at healthy levels: nothing issued.
        run(20);
        chk("t1_strobes", 8'(n_lp), 8'd0);
        chk("t1_busy",    8'(bus.busy), 8'd0);

        // Low main level with a full reservoir: exactly one refill.
        b_ls = n_ls;
        set_lvl(3, 40);
        run(10);
        chk("t2_refills", 8'(n_ls - b_ls), 8'd1);
        chk("t2_princ",   8'(bus.nivel_princ), 8'd23);
        chk("t2_sec",     8'(bus.nivel_sec),   8'd20);

        // Short reservoir flags failure; topping it up clears and refills.
        b_ls = n_ls;
        b_lp = n_lp;
        set_lvl(3, 10);
        run(5);
        chk("t3_falha_set", 8'(bus.falha_sec), 8'd1);
        chk("t3_no_load",   8'(n_lp - b_lp),   8'd0);
        bus.nivel_sec = 7'd20;
        run(6);
        chk("t3_falha_clr", 8'(bus.falha_sec),   8'd0);
        chk("t3_refills",   8'(n_ls - b_ls),     8'd1);
        chk("t3_princ",     8'(bus.nivel_princ), 8'd23);
        chk("t3_sec",       8'(bus.nivel_sec),   8'd0);

        // Simultaneous sealing and operator requests: sub first, add three cycles later.
        set_lvl(50, 40);
        run(3);
        log_perm.delete();
        log_cyc.delete();
        bus.ve_pulse = 1'b1;
        bus.op_req   = 1'b1;
        run(10);
        chk("t4_count", 8'(log_perm.size()), 8'd2);
        if (log_perm.size() == 2) begin
            chk("t4_first",  8'(log_perm[0]), 8'd3);
            chk("t4_second", 8'(log_perm[1]), 8'd2);
            chk("t4_gap",    8'(log_cyc[1] - log_cyc[0]), 8'd3);
        end
        chk("t4_net", 8'(bus.nivel_princ), 8'd50);

        // Full buffer drops operator add; empty buffer drops sealing consume.
        set_lvl(99, 40);
        run(3);
        b_lp   = n_lp;
        b_desc = n_desc;
        bus.op_req = 1'b1;
        run(6);
        chk("t5_full_desc", 8'(n_desc - b_desc), 8'd1);
        chk("t5_full_nold", 8'(n_lp - b_lp),     8'd0);
        chk("t5_full_lvl",  8'(bus.nivel_princ), 8'd99);
        set_lvl(0, 0);
        run(2);
        b_lp   = n_lp;
        b_desc = n_desc;
        bus.ve_pulse = 1'b1;
        run(6);
        chk("t5_empty_desc", 8'(n_desc - b_desc), 8'd1);
        chk("t5_empty_nold", 8'(n_lp - b_lp),     8'd0);
        chk("t5_ro",         8'(bus.ro),          8'd1);
        chk("t5_falha",      8'(bus.falha_sec),   8'd1);

        // Halted issue keeps the request pending until enable returns.
        set_lvl(50, 40);
        run(3);
        bus.enable = 1'b0;
        b_lp = n_lp;
        bus.ve_pulse = 1'b1;
        run(6);
        chk("t7_halted", 8'(n_lp - b_lp), 8'd0);
        bus.enable = 1'b1;
        run(6);
        chk("t7_served", 8'(n_lp - b_lp),     8'd1);
        chk("t7_level",  8'(bus.nivel_princ), 8'd49);

        // Reset in the middle of a transfer drops strobes and pending requests.
        set_lvl(3, 40);
        bus.op_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.load_sec) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_reach", 8'(found), 8'd1);
        clr     = 1'b1;
        prev_lp = 1'b0;
        prev_ls = 1'b0;
        #1;
        chk("t6_perm", 8'(bus.perm),       8'd0);
        chk("t6_lp",   8'(bus.load_princ), 8'd0);
        chk("t6_ls",   8'(bus.load_sec),   8'd0);
        chk("t6_busy", 8'(bus.busy),       8'd0);
        run(2);
        clr = 1'b0;
        log_perm.delete();
        log_cyc.delete();
        run(12);
        chk("t6_count", 8'(log_perm.size()), 8'd1);
        if (log_perm.size() >= 1) chk("t6_kind", 8'(log_perm[0]), 8'd1);
        chk("t6_princ", 8'(bus.nivel_princ), 8'd23);
        chk("t6_sec",   8'(bus.nivel_sec),   8'd20);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
